// File: rtl/icache_axi_rd_bridge_if.sv
// Bundles the I-cache miss port and the AXI4 AR/R channels seen by the read bridge.
// The slave modport is the bridge's view; master is the cache/interconnect side.
interface icache_axi_rd_bridge_if #(
    parameter int A_WIDTH = 32
);
    logic [A_WIDTH-1:0] m_a;
    logic               m_strobe;
    logic [31:0]        m_dout;
    logic               m_ready;
    logic               bus_err;

    logic [3:0]         arid;
    logic [A_WIDTH-1:0] araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arvalid;
    logic               arready;

    logic [3:0]         rid;
    logic [31:0]        rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport slave (
        input  m_a, m_strobe, arready, rid, rdata, rresp, rlast, rvalid,
        output m_dout, m_ready, bus_err, arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport master (
        output m_a, m_strobe, arready, rid, rdata, rresp, rlast, rvalid,
        input  m_dout, m_ready, bus_err, arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Turns one I-cache word miss into a single-beat AXI4 read; 3 cycles minimum request-to-m_ready.
// AXI stalls (arready/rvalid low) simply hold the FSM in AR/R; one transaction outstanding at a time.
module icache_axi_rd_bridge #(
    parameter int         A_WIDTH = 32,
    parameter logic [3:0] ID      = 4'b0000
) (
    input  logic                  clk,
    input  logic                  clrn,
    icache_axi_rd_bridge_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [A_WIDTH-1:0] r_addr_q;
    logic [31:0]        r_data_q;
    logic               r_err_q;
    logic               w_ar_hs;
    logic               w_r_hs;

    assign w_ar_hs = (r_state == ST_AR) && bus.arready;
    assign w_r_hs  = (r_state == ST_R)  && bus.rvalid;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.m_strobe) w_state_nxt = ST_AR;
            ST_AR:   if (bus.arready)  w_state_nxt = ST_R;
            ST_R:    if (bus.rvalid)   w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request address and returned word are only captured in their own states,
    // so cache-side changes mid-flight cannot disturb the transaction.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_addr_q <= '0;
            r_data_q <= '0;
            r_err_q  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && bus.m_strobe) begin
                r_addr_q <= {bus.m_a[A_WIDTH-1:2], 2'b00};
            end
            if (w_r_hs) begin
                r_data_q <= bus.rdata;
                r_err_q  <= (bus.rresp != 2'b00);
            end
        end
    end

    assign bus.arid    = ID;
    assign bus.araddr  = r_addr_q;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arvalid = (r_state == ST_AR);
    assign bus.rready  = (r_state == ST_R);
    assign bus.m_ready = (r_state == ST_DONE);
    assign bus.bus_err = (r_state == ST_DONE) && r_err_q;
    assign bus.m_dout  = r_data_q;
endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for the I-cache AXI read bridge: reset, zero-wait, stalls, address change, error, reset mid-AR.
module tb_icache_axi_rd_bridge;
    logic clk;
    logic clrn;
    int   checks;
    int   errors;
    int   ar_hs_cnt;
    int   r_hs_cnt;
    int   mrdy_cnt;
    int   ar_snap;
    int   r_snap;

    icache_axi_rd_bridge_if #(.A_WIDTH(32)) bus_if ();

    icache_axi_rd_bridge #(.A_WIDTH(32), .ID(4'b0000)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_if.arvalid && bus_if.arready) ar_hs_cnt <= ar_hs_cnt + 1;
        if (bus_if.rvalid && bus_if.rready)   r_hs_cnt  <= r_hs_cnt + 1;
        if (bus_if.m_ready)                   mrdy_cnt  <= mrdy_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ar_hs_cnt = 0;
        r_hs_cnt  = 0;
        mrdy_cnt  = 0;
        clrn             = 1'b0;
        bus_if.m_a       = 32'h0;
        bus_if.m_strobe  = 1'b1;
        bus_if.arready   = 1'b0;
        bus_if.rid       = 4'h0;
        bus_if.rdata     = 32'h0;
        bus_if.rresp     = 2'b00;
        bus_if.rlast     = 1'b1;
        bus_if.rvalid    = 1'b0;

        // Reset held with m_strobe high
        tick();
        tick();
        chk("rst_arvalid", {31'd0, bus_if.arvalid}, 32'd0);
        chk("rst_rready",  {31'd0, bus_if.rready},  32'd0);
        chk("rst_mready",  {31'd0, bus_if.m_ready}, 32'd0);
        chk("rst_buserr",  {31'd0, bus_if.bus_err}, 32'd0);
        chk("rst_mdout",   bus_if.m_dout,           32'd0);
        chk("rst_araddr",  bus_if.araddr,           32'd0);
        chk("const_arid",  {28'd0, bus_if.arid},    32'd0);
        chk("const_arlen", {24'd0, bus_if.arlen},   32'd0);
        chk("const_arsize", {29'd0, bus_if.arsize}, 32'd2);
        chk("const_arburst", {30'd0, bus_if.arburst}, 32'd1);
        clrn = 1'b1;
        tick();
        chk("post_rst_arvalid", {31'd0, bus_if.arvalid}, 32'd1);

        // Reset mid-AR abandons the request
        clrn = 1'b0;
        bus_if.m_strobe = 1'b0;
        tick();
        chk("midar_rst_arvalid", {31'd0, bus_if.arvalid}, 32'd0);
        clrn = 1'b1;
        tick();
        tick();
        tick();
        chk("midar_no_mready", mrdy_cnt, 32'd0);
        chk("midar_idle_arvalid", {31'd0, bus_if.arvalid}, 32'd0);

        // Zero-wait read
        bus_if.arready  = 1'b1;
        bus_if.rvalid   = 1'b1;
        bus_if.rdata    = 32'h3C08_BFC0;
        bus_if.m_a      = 32'h1FC0_0007;
        bus_if.m_strobe = 1'b1;
        tick();
        bus_if.m_strobe = 1'b0;
        chk("zw_c1_arvalid", {31'd0, bus_if.arvalid}, 32'd1);
        chk("zw_c1_araddr",  bus_if.araddr, 32'h1FC0_0004);
        tick();
        chk("zw_c2_rready", {31'd0, bus_if.rready},  32'd1);
        chk("zw_c2_mready", {31'd0, bus_if.m_ready}, 32'd0);
        tick();
        chk("zw_c3_mready", {31'd0, bus_if.m_ready}, 32'd1);
        chk("zw_c3_mdout",  bus_if.m_dout, 32'h3C08_BFC0);
        chk("zw_c3_buserr", {31'd0, bus_if.bus_err}, 32'd0);
        tick();
        chk("zw_c4_mready", {31'd0, bus_if.m_ready}, 32'd0);

        // Stalls: 4 cycles of arready low, 5 of rvalid low -> m_ready at cycle 12
        bus_if.arready  = 1'b0;
        bus_if.rvalid   = 1'b0;
        bus_if.rdata    = 32'hCAFE_F00D;
        bus_if.m_a      = 32'h0000_1236;
        bus_if.m_strobe = 1'b1;
        ar_snap = ar_hs_cnt;
        r_snap  = r_hs_cnt;
        tick();
        bus_if.m_strobe = 1'b0;
        bus_if.m_a      = 32'h0000_9990;
        for (int i = 1; i <= 4; i++) begin
            chk("st_ar_arvalid", {31'd0, bus_if.arvalid}, 32'd1);
            chk("st_ar_araddr",  bus_if.araddr, 32'h0000_1234);
            tick();
        end
        bus_if.arready = 1'b1;
        chk("st_c5_arvalid", {31'd0, bus_if.arvalid}, 32'd1);
        tick();
        bus_if.arready = 1'b0;
        for (int i = 6; i <= 10; i++) begin
            chk("st_r_rready", {31'd0, bus_if.rready},  32'd1);
            chk("st_r_mready", {31'd0, bus_if.m_ready}, 32'd0);
            tick();
        end
        bus_if.rvalid = 1'b1;
        chk("st_c11_mready", {31'd0, bus_if.m_ready}, 32'd0);
        tick();
        bus_if.rvalid = 1'b0;
        chk("st_c12_mready", {31'd0, bus_if.m_ready}, 32'd1);
        chk("st_c12_mdout",  bus_if.m_dout, 32'hCAFE_F00D);
        tick();
        chk("st_ar_hs_once", ar_hs_cnt - ar_snap, 32'd1);
        chk("st_r_hs_once",  r_hs_cnt - r_snap,   32'd1);

        // Address change while in R; strobe stays high for a follow-on request
        bus_if.arready  = 1'b1;
        bus_if.m_a      = 32'h0000_0100;
        bus_if.m_strobe = 1'b1;
        tick();
        tick();
        bus_if.m_a = 32'h0000_0200;
        chk("ac_r_rready", {31'd0, bus_if.rready}, 32'd1);
        chk("ac_r_araddr", bus_if.araddr, 32'h0000_0100);
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = 32'h1111_0100;
        tick();
        bus_if.rvalid = 1'b0;
        chk("ac_done_mready", {31'd0, bus_if.m_ready}, 32'd1);
        chk("ac_done_mdout",  bus_if.m_dout, 32'h1111_0100);
        chk("ac_done_araddr", bus_if.araddr, 32'h0000_0100);
        tick();
        chk("ac_idle_arvalid", {31'd0, bus_if.arvalid}, 32'd0);
        chk("ac_idle_mready",  {31'd0, bus_if.m_ready}, 32'd0);
        tick();
        bus_if.m_strobe = 1'b0;
        chk("ac2_arvalid", {31'd0, bus_if.arvalid}, 32'd1);
        chk("ac2_araddr",  bus_if.araddr, 32'h0000_0200);
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = 32'h2222_0200;
        tick();
        tick();
        bus_if.rvalid = 1'b0;
        chk("ac2_mready", {31'd0, bus_if.m_ready}, 32'd1);
        chk("ac2_mdout",  bus_if.m_dout, 32'h2222_0200);
        tick();

        // Error response
        bus_if.rvalid   = 1'b1;
        bus_if.rresp    = 2'b10;
        bus_if.rdata    = 32'hDEAD_BEEF;
        bus_if.m_a      = 32'h0000_0040;
        bus_if.m_strobe = 1'b1;
        tick();
        bus_if.m_strobe = 1'b0;
        tick();
        tick();
        bus_if.rvalid = 1'b0;
        bus_if.rresp  = 2'b00;
        chk("err_mready", {31'd0, bus_if.m_ready}, 32'd1);
        chk("err_buserr", {31'd0, bus_if.bus_err}, 32'd1);
        chk("err_mdout",  bus_if.m_dout, 32'hDEAD_BEEF);
        tick();
        chk("err_idle_mready",  {31'd0, bus_if.m_ready}, 32'd0);
        chk("err_idle_buserr",  {31'd0, bus_if.bus_err}, 32'd0);
        chk("err_idle_arvalid", {31'd0, bus_if.arvalid}, 32'd0);
        tick();
        chk("total_mready_pulses", mrdy_cnt, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
